// File: rtl/vms_pkg.sv
// -----------------------------------------------------------------------------
// vms_pkg
// Shared types and helpers for the vector<->scalar memory sequencer.
//   vms_state_t : sequencer FSM encoding (IDLE, WRITE, READ, DRAIN, RESP)
//   lane_idx_w  : width of a lane index for a given lane count
//   TAG_RD_W    : width of the destination register tag
// -----------------------------------------------------------------------------
package vms_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } vms_state_t;

    localparam int TAG_RD_W = 5;

    function automatic int lane_idx_w(input int lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/vms_tag_delay.sv
// -----------------------------------------------------------------------------
// vms_tag_delay
// RAM_LAT-stage shift register carrying {valid, lane index} alongside a RAM
// read, so the returning data can be steered to the lane that requested it.
// Ports:
//   clk, rst       clock, synchronous active-low reset (clears all stages)
//   in_valid       a read address is issued this cycle
//   in_lane        lane index of that read
//   out_valid      RAM data for out_lane is on ram_rdata this cycle
//   out_lane       lane index emerging from the last stage
//   pending        a tag will still be in flight after the next shift
// -----------------------------------------------------------------------------
module vms_tag_delay #(
    parameter int RAM_LAT = 1,
    parameter int LW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [LW-1:0] in_lane,
    output logic          out_valid,
    output logic [LW-1:0] out_lane,
    output logic          pending
);

    logic [RAM_LAT-1:0] v_q;
    logic [LW-1:0]      lane_q [RAM_LAT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_q <= '0;
            for (int s = 0; s < RAM_LAT; s++) begin
                lane_q[s] <= '0;
            end
        end else begin
            v_q[0]    <= in_valid;
            lane_q[0] <= in_lane;
            for (int s = 1; s < RAM_LAT; s++) begin
                v_q[s]    <= v_q[s-1];
                lane_q[s] <= lane_q[s-1];
            end
        end
    end

    assign out_valid = v_q[RAM_LAT-1];
    assign out_lane  = lane_q[RAM_LAT-1];

    // The last stage drains on the next edge, so only earlier stages keep
    // the line busy.
    if (RAM_LAT == 1) begin : g_single
        assign pending = 1'b0;
    end else begin : g_multi
        assign pending = |v_q[RAM_LAT-2:0];
    end

endmodule

// File: rtl/vec_mem_sequencer.sv
// -----------------------------------------------------------------------------
// vec_mem_sequencer
// Vector<->scalar memory sequencer for the MEM stage. A vector store is
// serialised into LANES single-element RAM writes; a vector load issues LANES
// single-element reads and gathers the returning data into one response.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both 1. The request side accepts only in IDLE (req_ready); a requester that
// sees req_ready=0 holds its request. The response side presents rsp_* in RESP
// and holds them unchanged until rsp_ready=1.
//
// Build option: VMS_STRIDE_EN
//   defined   : element address = req_base + i*req_stride (mod 2^ADDR_W)
//   undefined : stride fixed at 1, req_stride is not used
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   req_valid/req_ready      request handshake
//   req_write                1 = store, 0 = load
//   req_base, req_stride     lane 0 address, element stride
//   req_rd                   destination tag echoed on the response
//   req_wdata                store data, lane i = [i*ELEM_W +: ELEM_W]
//   ram_addr/ram_wdata/ram_wren/ram_rdata   single-element RAM port
//   rsp_valid/rsp_ready      response handshake
//   rsp_write, rsp_rd        echo of the request
//   rsp_rdata                gathered load data (zero for stores)
//   busy                     FSM not in IDLE, drives the pipeline stall
//   state_dbg                current FSM state
// -----------------------------------------------------------------------------
module vec_mem_sequencer
    import vms_pkg::*;
#(
    parameter int LANES   = 16,
    parameter int ELEM_W  = 16,
    parameter int ADDR_W  = 19,
    parameter int RAM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_base,
    input  logic [ADDR_W-1:0]         req_stride,
    input  logic [TAG_RD_W-1:0]       req_rd,
    input  logic [LANES*ELEM_W-1:0]   req_wdata,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [ELEM_W-1:0]         ram_wdata,
    output logic                      ram_wren,
    input  logic [ELEM_W-1:0]         ram_rdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [TAG_RD_W-1:0]       rsp_rd,
    output logic [LANES*ELEM_W-1:0]   rsp_rdata,
    output logic                      busy,
    output logic [2:0]                state_dbg
);

    localparam int LW    = lane_idx_w(LANES);
    localparam int VEC_W = LANES * ELEM_W;

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_WRITE = WRITE;
    localparam logic [2:0] S_READ  = READ;
    localparam logic [2:0] S_DRAIN = DRAIN;
    localparam logic [2:0] S_RESP  = RESP;

    logic [2:0]          state_q, state_d;
    logic [LW-1:0]       lane_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   step;
    logic                write_q;
    logic [TAG_RD_W-1:0] rd_q;
    logic [VEC_W-1:0]    wdata_q;
    logic [VEC_W-1:0]    rdata_q;

    logic                accept;
    logic                active;
    logic                last_lane;
    logic                tag_out_valid;
    logic [LW-1:0]       tag_out_lane;
    logic                tag_pending;

`ifdef VMS_STRIDE_EN
    logic [ADDR_W-1:0]   stride_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stride_q <= '0;
        end else if (accept) begin
            stride_q <= req_stride;
        end
    end

    assign step = stride_q;
`else
    logic unused_stride;

    assign unused_stride = ^req_stride;
    assign step          = ADDR_W'(1);
`endif

    assign accept    = req_valid && (state_q == S_IDLE);
    assign active    = (state_q == S_WRITE) || (state_q == S_READ);
    assign last_lane = (lane_q == LW'(LANES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid)   state_d = req_write ? S_WRITE : S_READ;
            S_WRITE: if (last_lane)   state_d = S_RESP;
            // The last read is still in the RAM pipeline after its address.
            S_READ:  if (last_lane)   state_d = S_DRAIN;
            S_DRAIN: if (!tag_pending) state_d = S_RESP;
            S_RESP:  if (rsp_ready)   state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lane_q  <= '0;
                addr_q  <= req_base;
                write_q <= req_write;
                rd_q    <= req_rd;
                wdata_q <= req_wdata;
                rdata_q <= '0;
            end else if (active) begin
                lane_q <= lane_q + LW'(1);
                // Wraps modulo 2^ADDR_W by construction.
                addr_q <= addr_q + step;
            end
            if (tag_out_valid) begin
                rdata_q[int'(tag_out_lane)*ELEM_W +: ELEM_W] <= ram_rdata;
            end
        end
    end

    vms_tag_delay #(
        .RAM_LAT (RAM_LAT),
        .LW      (LW)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state_q == S_READ),
        .in_lane   (lane_q),
        .out_valid (tag_out_valid),
        .out_lane  (tag_out_lane),
        .pending   (tag_pending)
    );

    assign ram_addr  = active ? addr_q : '0;
    assign ram_wren  = (state_q == S_WRITE);
    assign ram_wdata = (state_q == S_WRITE) ? wdata_q[int'(lane_q)*ELEM_W +: ELEM_W] : '0;

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_write = write_q;
    assign rsp_rd    = rd_q;
    assign rsp_rdata = rdata_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vec_mem_sequencer
// Directed bench for vec_mem_sequencer (LANES=16, ELEM_W=16, ADDR_W=19,
// RAM_LAT=1) with a behavioural single-cycle-latency RAM.
// -----------------------------------------------------------------------------
module tb_vec_mem_sequencer;
    import vms_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         req_valid, req_ready, req_write;
    logic [18:0]  req_base, req_stride;
    logic [4:0]   req_rd;
    logic [255:0] req_wdata;
    logic [18:0]  ram_addr;
    logic [15:0]  ram_wdata;
    logic         ram_wren;
    logic [15:0]  ram_rdata;
    logic         rsp_valid, rsp_ready, rsp_write;
    logic [4:0]   rsp_rd;
    logic [255:0] rsp_rdata;
    logic         busy;
    logic [2:0]   state_dbg;

    vec_mem_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_base(req_base), .req_stride(req_stride), .req_rd(req_rd),
        .req_wdata(req_wdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
        .ram_rdata(ram_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rd(rsp_rd), .rsp_rdata(rsp_rdata), .busy(busy),
        .state_dbg(state_dbg)
    );

    // ---------------- behavioural RAM ----------------
    // ram_init zeroes the array and loads a known pattern around the
    // address-space wrap point (0x7FFF8.. = 0x0200.., 0x00000.. = 0x0208..).
    logic        ram_init;
    logic [15:0] mem [0:(1<<19)-1];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < (1 << 19); k++) mem[k] <= 16'h0;
            for (int k = 0; k < 8; k++) begin
                mem[19'h7FFF8 + k] <= 16'(16'h0200 + k);
                mem[k]             <= 16'(16'h0208 + k);
            end
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [261:0]     exp_q[$];    // {write, rd, rdata}
    logic [35:0]      addr_q[$];   // {wren, addr, wdata}
    logic [15:0]      model_mem [int];

    initial begin
        for (int k = 0; k < 8; k++) begin
            model_mem[32'h7FFF8 + k] = 16'(16'h0200 + k);
            model_mem[k]             = 16'(16'h0208 + k);
        end
    end

    function automatic logic [15:0] model_rd(input logic [18:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return 16'h0;
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected RAM traffic and response for one request.
    task automatic push_req(input logic wr, input logic [18:0] base, input logic [18:0] stride,
                            input logic [4:0] rd, input logic [255:0] wd, input logic push_rsp);
        logic [18:0]  a;
        logic [18:0]  st;
        logic [255:0] data;
        data = '0;
`ifdef VMS_STRIDE_EN
        st = stride;
`else
        st = 19'd1;
`endif
        a = base;
        for (int i = 0; i < 16; i++) begin
            addr_q.push_back({wr, a, wr ? wd[i*16 +: 16] : 16'h0});
            if (wr) model_mem[int'(a)] = wd[i*16 +: 16];
            else    data[i*16 +: 16] = model_rd(a);
            a = a + st;
        end
        if (push_rsp) exp_q.push_back({wr, rd, data});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [35:0]  ea;
        logic [261:0] er;
        if (rst && !ram_init) begin
            if (state_dbg == WRITE || state_dbg == READ) begin
                n_vec++;
                if (addr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL ram_unexpected: addr %0h wren %0b, no access expected", ram_addr, ram_wren);
                end else begin
                    ea = addr_q.pop_front();
                    if (ram_addr !== ea[34:16] || ram_wren !== ea[35] ||
                        (ea[35] && ram_wdata !== ea[15:0])) begin
                        n_err++;
                        $display("FAIL ram_access: addr %0h wren %0b wdata %0h expected addr %0h wren %0b wdata %0h",
                                 ram_addr, ram_wren, ram_wdata, ea[34:16], ea[35], ea[15:0]);
                    end
                end
            end else if (ram_wren !== 1'b0) begin
                n_vec++;
                n_err++;
                $display("FAIL ram_wren_idle: got %0b expected 0", ram_wren);
            end
            if (rsp_valid && rsp_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected: rd %0d write %0b, no response expected", rsp_rd, rsp_write);
                end else begin
                    er = exp_q.pop_front();
                    if (rsp_write !== er[261] || rsp_rd !== er[260:256] || rsp_rdata !== er[255:0]) begin
                        n_err++;
                        $display("FAIL rsp: write %0b rd %0d rdata %0h expected write %0b rd %0d rdata %0h",
                                 rsp_write, rsp_rd, rsp_rdata, er[261], er[260:256], er[255:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [18:0] base, input logic [18:0] stride,
                             input logic [4:0] rd, input logic [255:0] wd);
        req_valid  = 1'b1;
        req_write  = wr;
        req_base   = base;
        req_stride = stride;
        req_rd     = rd;
        req_wdata  = wd;
    endtask

    // Counts cycles from the acceptance edge until rsp_valid appears.
    task automatic wait_rsp(input string name, input int exp_lat);
        int n;
        n = 1;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk(name, 256'(n), 256'(exp_lat));
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic run_req(input string name, input logic wr, input logic [18:0] base,
                           input logic [18:0] stride, input logic [4:0] rd,
                           input logic [255:0] wd, input int exp_lat);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        push_req(wr, base, stride, rd, wd, 1'b1);
        drive_req(wr, base, stride, rd, wd);
        tick();
        req_valid = 1'b0;
        wait_rsp(name, exp_lat);
        handshake();
    endtask

    // ---------------- stimulus ----------------
    logic [255:0] wd1, wd2, wd3;
    logic         saw_rsp;

    initial begin
        for (int i = 0; i < 16; i++) begin
            wd1[i*16 +: 16] = 16'(16'h0100 + i);
            wd2[i*16 +: 16] = 16'(16'h0400 + i);
            wd3[i*16 +: 16] = 16'(16'h0300 + i);
        end
        rst = 1'b0; ram_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_base = '0; req_stride = '0;
        req_rd = '0; req_wdata = '0; rsp_ready = 1'b0;

        // Reset held for three cycles.
        repeat (3) tick();
        chk("rst_req_ready", 256'(req_ready), 256'(1));
        chk("rst_busy",      256'(busy),      256'(0));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst_ram_wren",  256'(ram_wren),  256'(0));
        chk("rst_rsp_rdata", rsp_rdata,       256'(0));
        rst = 1'b1; ram_init = 1'b0;
        tick();

        // Store, load-back, address wrap.
        run_req("store_lat", 1'b1, 19'h00010, 19'd1, 5'd2, wd1, 17);
        run_req("load_lat",  1'b0, 19'h00010, 19'd1, 5'd7, '0, 18);
        run_req("wrap_lat",  1'b0, 19'h7FFF8, 19'd1, 5'd9, '0, 18);

        // Backpressure with a second request held behind it.
        push_req(1'b0, 19'h00010, 19'd1, 5'd3, '0, 1'b1);
        drive_req(1'b0, 19'h00010, 19'd1, 5'd3, '0);
        tick();
        req_valid = 1'b0;
        wait_rsp("bp_load_lat", 18);
        push_req(1'b1, 19'h00060, 19'd1, 5'd4, wd2, 1'b1);
        drive_req(1'b1, 19'h00060, 19'd1, 5'd4, wd2);
        for (int k = 0; k < 5; k++) begin
            chk("bp_req_ready", 256'(req_ready), 256'(0));
            chk("bp_rsp_valid", 256'(rsp_valid), 256'(1));
            chk("bp_rsp_rd",    256'(rsp_rd),    256'(3));
            chk("bp_rsp_rdata", rsp_rdata,       wd1);
            tick();
        end
        handshake();
        chk("bubble_req_ready", 256'(req_ready), 256'(1));
        chk("bubble_rsp_valid", 256'(rsp_valid), 256'(0));
        tick();
        req_valid = 1'b0;
        chk("b2b_busy", 256'(busy), 256'(1));
        wait_rsp("b2b_store_lat", 17);
        handshake();
        run_req("b2b_readback", 1'b0, 19'h00060, 19'd1, 5'd5, '0, 18);

        // Reset during cycle 8 of a load: aborted, no response.
        push_req(1'b0, 19'h00010, 19'd1, 5'd20, '0, 1'b0);
        drive_req(1'b0, 19'h00010, 19'd1, 5'd20, '0);
        tick();
        req_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        addr_q.delete();
        chk("abort_busy",      256'(busy),      256'(0));
        chk("abort_req_ready", 256'(req_ready), 256'(1));
        chk("abort_ram_wren",  256'(ram_wren),  256'(0));
        chk("abort_rsp_rdata", rsp_rdata,       256'(0));
        saw_rsp = 1'b0;
        repeat (20) begin
            saw_rsp = saw_rsp | rsp_valid;
            tick();
        end
        chk("abort_no_rsp", 256'(saw_rsp), 256'(0));

        // Strided accesses (unit stride when the option is not built in).
        run_req("stride4_lat",   1'b0, 19'h00000, 19'd4, 5'd11, '0, 18);
        run_req("stride0_lat",   1'b0, 19'h00013, 19'd0, 5'd12, '0, 18);
        run_req("stride0_store", 1'b1, 19'h00040, 19'd0, 5'd13, wd3, 17);
        run_req("stride0_check", 1'b0, 19'h00040, 19'd1, 5'd14, '0, 18);

        repeat (5) tick();
        chk("exp_q_drained",  256'(exp_q.size()),  256'(0));
        chk("addr_q_drained", 256'(addr_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
